// File: rtl/uart_fifo_port.sv
// uart_fifo_port: UART peripheral slave on the core memory port.
//
// 8N1 serializer/deserializer with TX and RX FIFOs, a programmable baud
// divisor, sticky error flags and a registered level interrupt.
//
// Bus handshake (valid/ready): ready mirrors valid, so every request is
// accepted in the cycle it is presented. One cycle after acceptance, rvalid
// is high for exactly one cycle. rdata carries the read value in that cycle
// and is 0 for writes.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   valid/ready      request / accept (ready = valid)
//   addr             byte address; only [3:2] select a register, all other
//                    bits must be 0 for a hit
//   write_en, wdata  1 = write, write data
//   rdata, rvalid    registered read data and completion strobe
//   uart_tx          serial out, idle high
//   uart_rx          serial in, asynchronous to clk
//   irq              registered level interrupt
//
// Register map (word offsets):
//   0x0 DATA    write: push TX byte; read: pop RX byte (0 when empty)
//   0x4 STATUS  {tx_ovf, tx_busy, frame_err, rx_overrun,
//                rx_empty, rx_full, tx_empty, tx_full}; W1C on bits 4, 5, 7
//   0x8 CTRL    {irq_txdone_en, irq_rx_en, rx_en, tx_en}
//   0xC DIV     clk cycles per bit, writes below 4 are stored as 4
module uart_fifo_port #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int TX_DEPTH    = 8,
  parameter int RX_DEPTH    = 8,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 868
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  output logic              ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic              write_en,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              uart_tx,
  input  logic              uart_rx,
  output logic              irq
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  logic       hit;
  logic [1:0] sel;
  logic       bus_wr;
  logic       bus_rd;
  logic       wr_data, wr_status, wr_ctrl, wr_div;
  logic       rd_data;

  assign ready  = valid;
  assign sel    = addr[3:2];
  assign hit    = (addr[ADDR_W-1:4] == '0) && (addr[1:0] == 2'b00);
  assign bus_wr = valid & write_en & hit;
  assign bus_rd = valid & ~write_en & hit;

  assign wr_data   = bus_wr & (sel == 2'd0);
  assign wr_status = bus_wr & (sel == 2'd1);
  assign wr_ctrl   = bus_wr & (sel == 2'd2);
  assign wr_div    = bus_wr & (sel == 2'd3);
  assign rd_data   = bus_rd & (sel == 2'd0);

  // Bits of wdata that no register stores; gathered so they read as used.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  // ---------------------------------------------------------------------
  // Control and divisor registers
  // ---------------------------------------------------------------------
  logic [3:0]       ctrl;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_m1;
  logic [DIV_W-1:0] half_m1;

  assign div_m1  = div_reg - DIV_W'(1);
  assign half_m1 = (div_reg >> 1) - DIV_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl    <= 4'h3;
      div_reg <= DIV_W'(DEFAULT_DIV);
    end else begin
      if (wr_ctrl) ctrl <= wdata[3:0];
      if (wr_div) begin
        if (wdata[DIV_W-1:0] < DIV_W'(4)) div_reg <= DIV_W'(4);
        else                              div_reg <= wdata[DIV_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wp, tx_rp;
  logic [TX_AW:0]   tx_cnt;
  logic             tx_full, tx_empty;
  logic             tx_push, tx_pop, tx_ovf_set;
  uart_state_t      tx_state;

  assign tx_full    = (tx_cnt == (TX_AW+1)'(TX_DEPTH));
  assign tx_empty   = (tx_cnt == '0);
  // The serializer pops as it leaves IDLE, which frees a slot in the same
  // cycle, so a bus push on a full FIFO still succeeds then.
  assign tx_pop     = (tx_state == S_IDLE) & ctrl[0] & ~tx_empty;
  assign tx_push    = wr_data & (~tx_full | tx_pop);
  assign tx_ovf_set = wr_data & tx_full & ~tx_pop;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + TX_AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + (TX_AW+1)'(1);
        2'b01:   tx_cnt <= tx_cnt - (TX_AW+1)'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // TX serializer. Each bit counter is reloaded from DIV at every bit
  // boundary, so a divisor change applies from the next bit onwards.
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] tx_tmr;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_sh;
  logic             tx_busy;

  assign tx_busy = (tx_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      tx_tmr   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          uart_tx <= 1'b1;
          if (tx_pop) begin
            tx_state <= S_START;
            tx_sh    <= tx_mem[tx_rp];
            tx_tmr   <= div_m1;
            uart_tx  <= 1'b0;
          end
        end
        S_START: begin
          if (tx_tmr == '0) begin
            tx_state <= S_DATA;
            tx_bit   <= '0;
            tx_tmr   <= div_m1;
            uart_tx  <= tx_sh[0];
          end else begin
            tx_tmr <= tx_tmr - DIV_W'(1);
          end
        end
        S_DATA: begin
          if (tx_tmr == '0) begin
            tx_tmr <= div_m1;
            if (tx_bit == 3'd7) begin
              tx_state <= S_STOP;
              uart_tx  <= 1'b1;
            end else begin
              tx_bit  <= tx_bit + 3'd1;
              tx_sh   <= {1'b0, tx_sh[7:1]};
              uart_tx <= tx_sh[1];
            end
          end else begin
            tx_tmr <= tx_tmr - DIV_W'(1);
          end
        end
        S_STOP: begin
          uart_tx <= 1'b1;
          if (tx_tmr == '0) tx_state <= S_IDLE;
          else              tx_tmr   <= tx_tmr - DIV_W'(1);
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // RX synchronizer and falling-edge detect. The flops reset high so the
  // idle line does not look like a start bit after reset.
  // ---------------------------------------------------------------------
  logic rx_s1, rx_s2, rx_prev;
  logic rx_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev & ~rx_s2;

  // ---------------------------------------------------------------------
  // RX deserializer: start bit checked at DIV/2, then one sample per bit
  // period, which lands each sample near mid-bit.
  // ---------------------------------------------------------------------
  uart_state_t      rx_state;
  logic [DIV_W-1:0] rx_tmr;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_sh;
  logic             rx_stop_smp;

  assign rx_stop_smp = (rx_state == S_STOP) & (rx_tmr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= S_IDLE;
      rx_tmr   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          if (ctrl[1] & rx_fall) begin
            rx_state <= S_START;
            rx_tmr   <= half_m1;
          end
        end
        S_START: begin
          if (rx_tmr == '0) begin
            if (rx_s2) begin
              rx_state <= S_IDLE;   // line back high: glitch, not a start bit
            end else begin
              rx_state <= S_DATA;
              rx_bit   <= '0;
              rx_tmr   <= div_m1;
            end
          end else begin
            rx_tmr <= rx_tmr - DIV_W'(1);
          end
        end
        S_DATA: begin
          if (rx_tmr == '0) begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_tmr <= div_m1;
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_tmr <= rx_tmr - DIV_W'(1);
          end
        end
        S_STOP: begin
          if (rx_tmr == '0) rx_state <= S_IDLE;
          else              rx_tmr   <= rx_tmr - DIV_W'(1);
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wp, rx_rp;
  logic [RX_AW:0]   rx_cnt;
  logic             rx_full, rx_empty;
  logic             rx_push_req, rx_push, rx_pop;
  logic             rx_ovr_set, frame_set;

  assign rx_full     = (rx_cnt == (RX_AW+1)'(RX_DEPTH));
  assign rx_empty    = (rx_cnt == '0);
  assign rx_pop      = rd_data & ~rx_empty;
  assign rx_push_req = rx_stop_smp & rx_s2;
  // A same-cycle bus pop makes room, so the byte is kept in that case.
  assign rx_push     = rx_push_req & (~rx_full | rx_pop);
  assign rx_ovr_set  = rx_push_req & rx_full & ~rx_pop;
  assign frame_set   = rx_stop_smp & ~rx_s2;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_sh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + RX_AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + (RX_AW+1)'(1);
        2'b01:   rx_cnt <= rx_cnt - (RX_AW+1)'(1);
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Sticky flags: a set in the same cycle as a W1C clear wins.
  // ---------------------------------------------------------------------
  logic tx_ovf, rx_overrun, frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ovf     <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      tx_ovf     <= tx_ovf_set | (tx_ovf     & ~(wr_status & wdata[7]));
      rx_overrun <= rx_ovr_set | (rx_overrun & ~(wr_status & wdata[4]));
      frame_err  <= frame_set  | (frame_err  & ~(wr_status & wdata[5]));
    end
  end

  // ---------------------------------------------------------------------
  // Read mux, response and interrupt
  // ---------------------------------------------------------------------
  logic [7:0]        status;
  logic [DATA_W-1:0] rd_mux;

  assign status = {tx_ovf, tx_busy, frame_err, rx_overrun,
                   rx_empty, rx_full, tx_empty, tx_full};

  always_comb begin
    rd_mux = '0;
    case (sel)
      2'd0: rd_mux[7:0]       = rx_empty ? 8'h00 : rx_mem[rx_rp];
      2'd1: rd_mux[7:0]       = status;
      2'd2: rd_mux[3:0]       = ctrl;
      2'd3: rd_mux[DIV_W-1:0] = div_reg;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      irq    <= 1'b0;
    end else begin
      rvalid <= valid;
      rdata  <= bus_rd ? rd_mux : '0;
      irq    <= (ctrl[2] & ~rx_empty) | (ctrl[3] & tx_empty & ~tx_busy);
    end
  end

endmodule
